// File: rtl/ifu.sv
// Instruction fetch unit: issues sequential fetch requests to the bus,
// collects in-order responses into a small fetch queue and presents the
// queue head to decode. Redirects flush the queue and discard responses
// that belong to the abandoned path.
//
// Handshake semantics (all interfaces): a transfer happens on a rising
// edge where valid && ready are both high. A source never withdraws
// valid, nor changes its payload, until the transfer happens. A sink may
// raise or drop ready at will.
module ifu #(
    parameter int unsigned     AW       = 32,
    parameter int unsigned     DW       = 32,
    parameter logic [AW-1:0]   RST_PC   = 32'h0000_0000,
    parameter int unsigned     FQ_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    // fetch bus master side
    output logic          ifetch_req_vld,
    output logic [AW-1:0] ifetch_req_pc,
    input  logic          ifetch_req_rdy,
    input  logic          ifetch_rsp_vld,
    output logic          ifetch_rsp_rdy,
    input  logic [DW-1:0] ifetch_rsp_ir,
    // redirect from execute
    input  logic          redir_vld,
    input  logic [AW-1:0] redir_pc,
    // decode side
    output logic          ir_vld,
    input  logic          ir_rdy,
    output logic [DW-1:0] ir,
    output logic [AW-1:0] ir_pc
);

    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned PW = $clog2(FQ_DEPTH);

    logic          run_q;
    logic          hold_q,       hold_d;
    logic [AW-1:0] fpc_q,        fpc_d;
    logic          stale_pend_q, stale_pend_d;
    logic [AW-1:0] stale_pc_q,   stale_pc_d;
    logic [AW-1:0] rpc_q,        rpc_d;
    logic [CW-1:0] inflight_q,   inflight_d;
    logic [CW-1:0] drop_q,       drop_d;
    logic [CW-1:0] fq_cnt_q,     fq_cnt_d;
    logic [PW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,     rd_ptr_d;

    logic [DW-1:0] fq_ir_q [FQ_DEPTH];
    logic [AW-1:0] fq_pc_q [FQ_DEPTH];

    logic [CW:0]   used;
    logic          credit_ok;
    logic          acc;
    logic          rsp_fire;
    logic          drop_rsp;
    logic          push;
    logic          pop;

    // Credit, handshake and queue-event decode
    always_comb begin
        used           = {1'b0, inflight_q} + {1'b0, fq_cnt_q};
        credit_ok      = (used < (CW + 1)'(FQ_DEPTH));
        // A held request stays up regardless of credit; it consumed its
        // credit when it first asserted.
        ifetch_req_vld = run_q & ~rst & (hold_q | credit_ok);
        // While a redirect is pending behind a held request, the held PC
        // stays on the bus and fpc already points at the new path.
        ifetch_req_pc  = stale_pend_q ? stale_pc_q : fpc_q;
        ifetch_rsp_rdy = run_q & ~rst;
        acc            = ifetch_req_vld & ifetch_req_rdy;
        rsp_fire       = ifetch_rsp_vld & ifetch_rsp_rdy;
        drop_rsp       = rsp_fire & (drop_q != '0);
        // A response coinciding with a redirect never enters the queue.
        push           = rsp_fire & (drop_q == '0) & ~redir_vld;
        pop            = ir_vld & ir_rdy & ~redir_vld;
    end

    // Next-state computation for PCs, counters, pointers and redirect handling
    always_comb begin
        hold_d       = ifetch_req_vld & ~ifetch_req_rdy;
        fpc_d        = fpc_q;
        stale_pend_d = stale_pend_q;
        stale_pc_d   = stale_pc_q;
        rpc_d        = rpc_q;
        drop_d       = drop_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        inflight_d   = inflight_q + CW'(acc) - CW'(rsp_fire);
        fq_cnt_d     = fq_cnt_q + CW'(push) - CW'(pop);

        if (acc) begin
            if (stale_pend_q) begin
                // The stale request goes out without advancing fpc; its
                // response must be thrown away.
                stale_pend_d = 1'b0;
            end else begin
                fpc_d = fpc_q + AW'(4);
            end
        end

        if (drop_rsp) begin
            drop_d = drop_q - CW'(1);
        end
        if (acc && stale_pend_q) begin
            drop_d = drop_d + CW'(1);
        end

        if (push) begin
            rpc_d    = rpc_q + AW'(4);
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (redir_vld) begin
            fq_cnt_d = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            rpc_d    = redir_pc;
            fpc_d    = redir_pc;
            // Everything still outstanding after this edge belongs to the
            // old path, including a request accepted in this very cycle.
            drop_d   = inflight_d;
            if (ifetch_req_vld && !ifetch_req_rdy) begin
                stale_pend_d = 1'b1;
                stale_pc_d   = ifetch_req_pc;
            end else begin
                stale_pend_d = 1'b0;
            end
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q        <= 1'b0;
            hold_q       <= 1'b0;
            fpc_q        <= RST_PC;
            stale_pend_q <= 1'b0;
            stale_pc_q   <= RST_PC;
            rpc_q        <= RST_PC;
            inflight_q   <= '0;
            drop_q       <= '0;
            fq_cnt_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            run_q        <= 1'b1;
            hold_q       <= hold_d;
            fpc_q        <= fpc_d;
            stale_pend_q <= stale_pend_d;
            stale_pc_q   <= stale_pc_d;
            rpc_q        <= rpc_d;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
            fq_cnt_q     <= fq_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Fetch queue storage; contents are qualified by fq_cnt so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fq_ir_q[wr_ptr_q] <= ifetch_rsp_ir;
            fq_pc_q[wr_ptr_q] <= rpc_q;
        end
    end

    // Decode-facing outputs come straight from registered queue state
    always_comb begin
        ir_vld = (fq_cnt_q != '0);
        ir     = fq_ir_q[rd_ptr_q];
        ir_pc  = fq_pc_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: an in-order fetch bus model, a spec-level model of the
// instruction stream decode must see, and directed scenarios.
module tb_ifu;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- main DUT signals ----------------
    logic          req_vld, req_rdy, rsp_vld, rsp_rdy;
    logic [AW-1:0] req_pc;
    logic [DW-1:0] rsp_ir;
    logic          redir_vld;
    logic [AW-1:0] redir_pc;
    logic          ir_vld, ir_rdy;
    logic [DW-1:0] ir;
    logic [AW-1:0] ir_pc;

    // ---------------- wrap DUT signals ----------------
    logic          req_vld2, req_rdy2, rsp_vld2, rsp_rdy2;
    logic [AW-1:0] req_pc2;
    logic [DW-1:0] rsp_ir2;
    logic          redir_vld2;
    logic [AW-1:0] redir_pc2;
    logic          ir_vld2, ir_rdy2;
    logic [DW-1:0] ir2;
    logic [AW-1:0] ir_pc2;

    ifu #(.AW(AW), .DW(DW), .RST_PC(32'h0000_0000), .FQ_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .ifetch_req_vld(req_vld), .ifetch_req_pc(req_pc), .ifetch_req_rdy(req_rdy),
        .ifetch_rsp_vld(rsp_vld), .ifetch_rsp_rdy(rsp_rdy), .ifetch_rsp_ir(rsp_ir),
        .redir_vld(redir_vld), .redir_pc(redir_pc),
        .ir_vld(ir_vld), .ir_rdy(ir_rdy), .ir(ir), .ir_pc(ir_pc)
    );

    ifu #(.AW(AW), .DW(DW), .RST_PC(32'hFFFF_FFF8), .FQ_DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst(rst),
        .ifetch_req_vld(req_vld2), .ifetch_req_pc(req_pc2), .ifetch_req_rdy(req_rdy2),
        .ifetch_rsp_vld(rsp_vld2), .ifetch_rsp_rdy(rsp_rdy2), .ifetch_rsp_ir(rsp_ir2),
        .redir_vld(redir_vld2), .redir_pc(redir_pc2),
        .ir_vld(ir_vld2), .ir_rdy(ir_rdy2), .ir(ir2), .ir_pc(ir_pc2)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [AW-1:0] pc;
        int            epoch;
        int            due;
    } bus_t;

    bus_t          bus_q[$];
    logic [AW-1:0] mfq[$];
    logic [AW-1:0] pop_log[$];
    logic [DW-1:0] pop_ir_log[$];
    logic [AW-1:0] bus2_pc[$];
    int            bus2_due[$];
    logic [AW-1:0] pop2_log[$];

    logic [AW-1:0] exp_stream_pc;
    logic [AW-1:0] exp_req_pc;
    logic [AW-1:0] held_pc;
    bit            held_prev;
    bit            stale;
    bit            prev_rst;
    bit            started;
    int            epoch;
    int            cyc;
    int            bus_lat;
    int            acc_cnt;
    int            drop_cnt;

    bit            last_req_vld, last_rsp_vld, last_rsp_rdy, last_ir_vld, last_acc;
    logic [AW-1:0] last_req_pc, last_acc_pc;

    // Instruction memory contents: distinct word per address
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] pc);
        return {~pc[15:0], pc[15:0]} ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver + model + compare, one clock per call ----------------
    task automatic step(input bit r, input bit rv, input logic [AW-1:0] rp,
                        input bit qr, input bit irr);
        bit   acc, fire, pop;
        bus_t e;
        @(negedge clk);
        rst       = r;
        redir_vld = rv;
        redir_pc  = rp;
        req_rdy   = qr;
        ir_rdy    = irr;
        if (bus_q.size() != 0 && bus_q[0].due <= cyc) begin
            rsp_vld = 1'b1;
            rsp_ir  = mem_f(bus_q[0].pc);
        end else begin
            rsp_vld = 1'b0;
            rsp_ir  = '0;
        end
        if (bus2_pc.size() != 0 && bus2_due[0] <= cyc) begin
            rsp_vld2 = 1'b1;
            rsp_ir2  = mem_f(bus2_pc[0]);
        end else begin
            rsp_vld2 = 1'b0;
            rsp_ir2  = '0;
        end
        #1;

        if (started) begin
            if (prev_rst) begin
                chk("rst_req_vld", req_vld, 0);
                chk("rst_rsp_rdy", rsp_rdy, 0);
                chk("rst_ir_vld", ir_vld, 0);
            end else begin
                chk("rsp_rdy", rsp_rdy, !r);
                chk("ir_vld", ir_vld, mfq.size() != 0);
                if (ir_vld && mfq.size() != 0) begin
                    chk("ir_pc", ir_pc, mfq[0]);
                    chk("ir", ir, mem_f(mfq[0]));
                end
                if (r) begin
                    chk("rst_req_vld_now", req_vld, 0);
                end else if (held_prev) begin
                    chk("hold_vld", req_vld, 1);
                    chk("hold_pc", req_pc, held_pc);
                end else if (req_vld) begin
                    chk("credit", (bus_q.size() + mfq.size()) < DEPTH, 1);
                end
            end
        end

        acc  = req_vld && req_rdy;
        fire = rsp_vld && rsp_rdy;
        pop  = ir_vld && ir_rdy && !rv;
        last_req_vld = req_vld;
        last_req_pc  = req_pc;
        last_rsp_vld = rsp_vld;
        last_rsp_rdy = rsp_rdy;
        last_ir_vld  = ir_vld;
        last_acc     = acc;
        last_acc_pc  = req_pc;

        if (r) begin
            bus_q.delete();
            mfq.delete();
            exp_stream_pc = 32'h0;
            exp_req_pc    = 32'h0;
            held_prev     = 1'b0;
            stale         = 1'b0;
            prev_rst      = 1'b1;
            epoch++;
        end else begin
            prev_rst = 1'b0;
            if (pop) begin
                chk("stream_pc", ir_pc, exp_stream_pc);
                exp_stream_pc += 32'd4;
                if (mfq.size() != 0) void'(mfq.pop_front());
                pop_log.push_back(ir_pc);
                pop_ir_log.push_back(ir);
            end
            if (fire && bus_q.size() != 0) begin
                e = bus_q.pop_front();
                if (e.epoch != epoch) drop_cnt++;
                else if (!rv) mfq.push_back(e.pc);
            end
            if (acc) begin
                if (stale) begin
                    e.epoch = -1;
                    stale   = 1'b0;
                end else begin
                    chk("req_pc", req_pc, exp_req_pc);
                    exp_req_pc += 32'd4;
                    e.epoch = epoch;
                end
                e.pc  = req_pc;
                e.due = cyc + bus_lat;
                bus_q.push_back(e);
                acc_cnt++;
            end
            if (rv) begin
                epoch++;
                mfq.delete();
                exp_stream_pc = rp;
                exp_req_pc    = rp;
                if (req_vld && !req_rdy) stale = 1'b1;
            end
            held_prev = req_vld && !req_rdy;
            held_pc   = req_pc;
            chk("fq_bound", mfq.size() <= DEPTH, 1);
        end

        // wrap instance: always-ready bus with one-cycle responses
        if (r) begin
            bus2_pc.delete();
            bus2_due.delete();
        end else begin
            if (ir_vld2) pop2_log.push_back(ir_pc2);
            if (rsp_vld2 && rsp_rdy2 && bus2_pc.size() != 0) begin
                void'(bus2_pc.pop_front());
                void'(bus2_due.pop_front());
            end
            if (req_vld2) begin
                bus2_pc.push_back(req_pc2);
                bus2_due.push_back(cyc + 1);
            end
        end
        started = 1'b1;
        cyc++;
    endtask

    task automatic do_reset();
        repeat (2) step(1, 0, '0, 1, 1);
        pop_log.delete();
        pop_ir_log.delete();
        acc_cnt  = 0;
        drop_cnt = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        rst = 1'b1; redir_vld = 1'b0; redir_pc = '0; req_rdy = 1'b1; ir_rdy = 1'b1;
        rsp_vld = 1'b0; rsp_ir = '0;
        req_rdy2 = 1'b1; ir_rdy2 = 1'b1; redir_vld2 = 1'b0; redir_pc2 = '0;
        rsp_vld2 = 1'b0; rsp_ir2 = '0;
        started = 1'b0; prev_rst = 1'b0; held_prev = 1'b0; stale = 1'b0;
        epoch = 0; cyc = 0; bus_lat = 1; acc_cnt = 0; drop_cnt = 0;
        exp_stream_pc = '0; exp_req_pc = '0; held_pc = '0;

        // Streaming from reset, one-cycle bus, decode always ready
        repeat (3) step(1, 0, '0, 1, 1);
        pop_log.delete();
        pop2_log.delete();
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 1);
        chk("first_req_vld", last_req_vld, 1);
        chk("first_req_pc", last_req_pc, 32'h0);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 1);
        n0 = pop_log.size();
        repeat (8) step(0, 0, '0, 1, 1);
        chk("stream_rate", pop_log.size() - n0, 8);
        chk("stream_len", pop_log.size() >= 3, 1);
        if (pop_log.size() >= 3) begin
            chk("stream_pc0", pop_log[0], 32'h0);
            chk("stream_pc1", pop_log[1], 32'h4);
            chk("stream_pc2", pop_log[2], 32'h8);
        end
        chk("wrap_len", pop2_log.size() >= 3, 1);
        if (pop2_log.size() >= 3) begin
            chk("wrap_pc0", pop2_log[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", pop2_log[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", pop2_log[2], 32'h0000_0000);
        end

        // Decode backpressure: credit limits acceptances to the queue depth
        do_reset();
        repeat (14) step(0, 0, '0, 1, 0);
        chk("bp_acc_cnt", acc_cnt, 4);
        chk("bp_req_vld_off", last_req_vld, 0);
        repeat (12) step(0, 0, '0, 1, 1);
        chk("bp_len", pop_log.size() >= 5, 1);
        if (pop_log.size() >= 5) begin
            chk("bp_pc0", pop_log[0], 32'h0);
            chk("bp_pc3", pop_log[3], 32'hC);
            chk("bp_pc4", pop_log[4], 32'h10);
        end

        // Redirect with two requests outstanding (two-cycle bus)
        do_reset();
        bus_lat = 2;
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 1);
        step(0, 1, 32'h100, 1, 1);
        chk("rd_rsp_same_cycle", last_rsp_vld, 1);
        pop_log.delete();
        pop_ir_log.delete();
        repeat (12) step(0, 0, '0, 1, 1);
        chk("rd_drop_cnt", drop_cnt, 2);
        chk("rd_len", pop_log.size() >= 1, 1);
        if (pop_log.size() >= 1) begin
            chk("rd_first_pc", pop_log[0], 32'h100);
            chk("rd_first_ir", pop_ir_log[0], mem_f(32'h100));
        end

        // Redirect while a request is held by bus backpressure
        do_reset();
        bus_lat = 1;
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 0, 1);
        chk("st_held_pc", last_req_pc, 32'h8);
        drop_cnt = 0;
        step(0, 1, 32'h40, 0, 1);
        chk("st_redir_vld", last_req_vld, 1);
        chk("st_redir_pc", last_req_pc, 32'h8);
        pop_log.delete();
        step(0, 0, '0, 0, 1);
        chk("st_still_pc", last_req_pc, 32'h8);
        step(0, 0, '0, 1, 1);
        chk("st_acc_stale", last_acc, 1);
        chk("st_acc_stale_pc", last_acc_pc, 32'h8);
        step(0, 0, '0, 1, 1);
        chk("st_next_pc", last_acc_pc, 32'h40);
        repeat (6) step(0, 0, '0, 1, 1);
        chk("st_drop_cnt", drop_cnt, 1);
        chk("st_len", pop_log.size() >= 1, 1);
        if (pop_log.size() >= 1) chk("st_first_pc", pop_log[0], 32'h40);

        // Redirect colliding with a response and a pop, then back-to-back redirects
        do_reset();
        repeat (6) step(0, 0, '0, 1, 1);
        step(0, 1, 32'h200, 1, 1);
        chk("co_rsp_vld", last_rsp_vld, 1);
        chk("co_ir_vld", last_ir_vld, 1);
        step(0, 0, '0, 1, 1);
        chk("co_empty", last_ir_vld, 0);
        repeat (3) step(0, 0, '0, 1, 1);
        step(0, 1, 32'h300, 1, 1);
        step(0, 1, 32'h400, 1, 1);
        pop_log.delete();
        repeat (8) step(0, 0, '0, 1, 1);
        chk("b2b_len", pop_log.size() >= 1, 1);
        if (pop_log.size() >= 1) chk("b2b_first_pc", pop_log[0], 32'h400);

        // Reset in the middle of a stream
        repeat (4) step(0, 0, '0, 1, 1);
        step(1, 0, '0, 1, 1);
        step(1, 0, '0, 1, 1);
        chk("mr_req_vld", last_req_vld, 0);
        chk("mr_rsp_rdy", last_rsp_rdy, 0);
        chk("mr_ir_vld", last_ir_vld, 0);
        pop_log.delete();
        repeat (8) step(0, 0, '0, 1, 1);
        chk("mr_len", pop_log.size() >= 1, 1);
        if (pop_log.size() >= 1) chk("mr_first_pc", pop_log[0], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter AW, default 32, address/PC width.
REQ-002 Parameter DW, default 32, instruction width.
REQ-003 Parameter RST_PC, default 32'h0000_0000, fetch address after reset.
REQ-004 Parameter FQ_DEPTH, default 4, fetch-queue entries, power of two, min 2.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ifetch  ifetch_if_t.master  -  drives req_vld, req_pc[AW] and rsp_rdy; receives req_rdy, rsp_vld and rsp_ir[DW]; connects to biu ifetch slave.
REQ-008 redir_vld  in  1  one-cycle redirect strobe from execute (branch/jump taken).
REQ-009 redir_pc  in  AW  redirect target, valid with redir_vld.
REQ-010 ir_vld  out  1  fetch-queue head valid toward decode.
REQ-011 ir_rdy  in  1  decode accepts head.
REQ-012 ir  out  DW  head instruction.
REQ-013 ir_pc  out  AW  PC of head instruction.

Function
REQ-014 Request PC register fpc; a request is accepted on req_vld && req_rdy; fpc += 4 on each acceptance, wrapping mod 2^AW.
REQ-015 inflight counts accepted requests without a response; +1 on acceptance, -1 on rsp_vld && rsp_rdy; both in one cycle leaves it unchanged.
REQ-016 Credit rule: req_vld asserts only when inflight + fq_cnt < FQ_DEPTH; counter width clog2(FQ_DEPTH+1); fq overflow is impossible.
REQ-017 Once asserted, req_vld and req_pc hold stable until accepted, including across a redirect and while credit is exhausted.
REQ-018 rsp_rdy is constant 1 outside reset.
REQ-019 Responses arrive in request order; rpc tracks the PC of the next expected response; rpc += 4 per kept response.
REQ-020 drop counts responses to discard; a response with drop > 0 is discarded and drop decrements; otherwise {rsp_ir, rpc} is pushed at the fq tail.
REQ-021 On redir_vld: fq flushed (fq_cnt = 0); rpc = redir_pc; fpc = redir_pc.
REQ-022 On redir_vld: drop = inflight value after that cycle's acceptance and response updates.
REQ-023 On redir_vld with a held, unaccepted request: stale_pend = 1; drop += 1 when that request is accepted; fpc does not advance on that acceptance; next request uses redir_pc.
REQ-024 Same-cycle redirect and response: the response is judged against the pre-redirect drop and never enters the flushed fq.
REQ-025 Same-cycle redirect and ir pop: flush wins; the pop has no other effect.
REQ-026 Same-cycle push and pop: fq_cnt unchanged; pointers wrap mod FQ_DEPTH.
REQ-027 ir_vld = (fq_cnt != 0); ir and ir_pc come from registered fq head with no combinational path from ifetch inputs.
REQ-028 Back-to-back redirects: each redirect fully overrides the previous one; drop is recomputed per REQ-022/023.
REQ-029 Latency: response edge to ir_vld high is 1 cycle; reset deassert to first req_vld high is 1 cycle.

Reset
REQ-030 While rst = 1: fpc = rpc = RST_PC; inflight = drop = fq_cnt = 0; stale_pend = 0; fq pointers = 0.
REQ-031 While rst = 1: req_vld = 0; rsp_rdy = 0; ir_vld = 0.
REQ-032 Reset mid-operation discards all in-flight state; external bus must be reset in the same cycle.

Verification
REQ-033 Stream: req_rdy = 1, 1-cycle response, ir_rdy = 1 -> ir_pc sequence 0x0, 0x4, 0x8 ...; one ir per cycle after fill.
REQ-034 Backpressure: ir_rdy = 0, FQ_DEPTH = 4 -> exactly 4 acceptances, then req_vld = 0; ir_rdy = 1 resumes with no loss or duplication.
REQ-035 Redirect: redirect to 0x100 with 2 in flight -> 2 responses dropped; first ir_pc = 0x100 with ir = mem[0x100].
REQ-036 Redirect during stall: req_vld held at 0x8 with req_rdy = 0, redirect to 0x40 -> 0x8 stays stable until accepted; its response is dropped; next req_pc = 0x40.
REQ-037 Collisions: redirect in the same cycle as rsp_vld and ir pop -> fq empty next cycle; no stale ir ever presented.
REQ-038 Wrap and reset: RST_PC = 0xFFFF_FFF8 -> ir_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; rst asserted mid-stream -> outputs per REQ-031 next cycle.
